// File: rtl/dcache_wb_ctrl_pkg.sv
// Shared types and default geometry for the write-back data cache controller.
// The address split widths are derived from the default geometry.
package dcache_wb_ctrl_pkg;

  localparam int DC_ADDR_W = 13;
  localparam int DC_DATA_W = 16;
  localparam int DC_SETS   = 32;
  localparam int DC_WORDS  = 4;

  localparam int OFF_W = $clog2(DC_WORDS);
  localparam int IDX_W = $clog2(DC_SETS);
  localparam int TAG_W = DC_ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WB   = 2'b01,
    FILL = 2'b10,
    DONE = 2'b11
  } dc_state_t;

endpackage

// File: rtl/dcache_data_array.sv
// Cache data storage: one write port and one asynchronous read port.
// Word-addressed by {idx, off}.
module dcache_data_array
  import dcache_wb_ctrl_pkg::*;
#(
  parameter int DATA_W = DC_DATA_W,
  parameter int AW     = IDX_W + OFF_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << AW];

  // NOTE: the data storage has no reset; valid bits gate every use of it,
  // and leaving it unreset lets synthesis map it onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back data cache: hit path, dirty-victim write-back,
// multi-beat line fill and a snoop lookup/invalidate port.
module dcache_wb_ctrl
  import dcache_wb_ctrl_pkg::*;
#(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int DATA_W = DC_DATA_W,
  parameter int SETS   = DC_SETS,
  parameter int WORDS  = DC_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              d_rdy,
  output logic              read_miss,
  output logic              write_miss,
  output logic [1:0]        miss_state,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              snoop_vld,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              snoop_inv,
  output logic              snoop_hit,
  output logic              snoop_dirty
);

  localparam int OFF_BITS = $clog2(WORDS);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS;
  localparam int LINE_AW  = IDX_BITS + OFF_BITS;
  localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(WORDS - 1);
  localparam logic [OFF_BITS-1:0] BEAT_ZERO = '0;

  dc_state_t           state;
  logic [OFF_BITS-1:0] beat;
  logic [OFF_BITS-1:0] next_beat;
  logic                fill_killed;

  logic [TAG_BITS-1:0] tag_q [SETS];
  logic [SETS-1:0]     valid_q;
  logic [SETS-1:0]     dirty_q;

  logic [OFF_BITS-1:0] cpu_off;
  logic [IDX_BITS-1:0] cpu_idx;
  logic [TAG_BITS-1:0] cpu_tag;
  logic [IDX_BITS-1:0] snp_idx;
  logic [TAG_BITS-1:0] snp_tag;

  assign cpu_off = cpu_addr[OFF_BITS-1:0];
  assign cpu_idx = cpu_addr[LINE_AW-1:OFF_BITS];
  assign cpu_tag = cpu_addr[ADDR_W-1:LINE_AW];
  assign snp_idx = snoop_addr[LINE_AW-1:OFF_BITS];
  assign snp_tag = snoop_addr[ADDR_W-1:LINE_AW];

  logic cpu_req, line_hit, victim_dirty;
  logic snoop_kill, snoop_kill_set, cpu_hit;
  logic beat_ack, last_ack, miss_start, fill_start, fill_done, fill_snooped;

  assign cpu_req      = cpu_re | cpu_we;
  assign line_hit     = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign victim_dirty = valid_q[cpu_idx] && dirty_q[cpu_idx];

  assign snoop_hit      = valid_q[snp_idx] && (tag_q[snp_idx] == snp_tag);
  assign snoop_dirty    = snoop_hit && dirty_q[snp_idx];
  assign snoop_kill     = snoop_vld && snoop_inv && snoop_hit;
  // An invalidate on the CPU's set wins; the CPU simply retries next cycle.
  assign snoop_kill_set = snoop_kill && (snp_idx == cpu_idx);

  assign cpu_hit = cpu_req && line_hit && !snoop_kill_set;
  assign d_rdy   = ((state == IDLE) || (state == DONE)) && cpu_hit;

  assign beat_ack   = mem_req && mem_ack;
  assign last_ack   = beat_ack && (beat == LAST_BEAT);
  assign next_beat  = beat + OFF_BITS'(1);
  assign miss_start = (state == IDLE) && cpu_req && !line_hit && !snoop_kill_set;
  assign fill_start = (miss_start && !victim_dirty) || ((state == WB) && last_ack);
  assign fill_done  = (state == FILL) && last_ack;
  // The in-flight line is invalid, so the ordinary snoop lookup cannot see it.
  assign fill_snooped = (state == FILL) && snoop_vld && snoop_inv &&
                        (snp_idx == cpu_idx) && (snp_tag == cpu_tag);

  logic                arr_we;
  logic [LINE_AW-1:0]  arr_waddr, arr_raddr;
  logic [DATA_W-1:0]   arr_wdata, arr_rdata;

  assign arr_we    = ((state == FILL) && beat_ack) || (d_rdy && cpu_we);
  assign arr_waddr = (state == FILL) ? {cpu_idx, beat} : {cpu_idx, cpu_off};
  assign arr_wdata = (state == FILL) ? mem_rdata : cpu_wdata;
  assign arr_raddr = (state == WB)   ? {cpu_idx, beat} : {cpu_idx, cpu_off};

  dcache_data_array #(
    .DATA_W (DATA_W),
    .AW     (LINE_AW)
  ) u_data (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  assign cpu_rdata  = arr_rdata;
  assign mem_wdata  = (state == WB) ? arr_rdata : '0;
  assign miss_state = state;

  // Snoop clears are placed last so they override same-edge FSM updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (d_rdy && cpu_we) dirty_q[cpu_idx] <= 1'b1;
      if ((state == WB) && last_ack) dirty_q[cpu_idx] <= 1'b0;
      if (fill_start) valid_q[cpu_idx] <= 1'b0;
      if (fill_done) begin
        valid_q[cpu_idx] <= !(fill_killed || fill_snooped);
        dirty_q[cpu_idx] <= 1'b0;
      end
      if (snoop_kill) begin
        valid_q[snp_idx] <= 1'b0;
        dirty_q[snp_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) tag_q[cpu_idx] <= cpu_tag;
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat        <= '0;
      fill_killed <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      read_miss   <= 1'b0;
      write_miss  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss_start) begin
            beat        <= '0;
            fill_killed <= 1'b0;
            mem_req     <= 1'b1;
            read_miss   <= cpu_re;
            write_miss  <= cpu_we;
            if (victim_dirty) begin
              state    <= WB;
              mem_we   <= 1'b1;
              mem_addr <= {tag_q[cpu_idx], cpu_idx, BEAT_ZERO};
            end else begin
              state    <= FILL;
              mem_we   <= 1'b0;
              mem_addr <= {cpu_tag, cpu_idx, BEAT_ZERO};
            end
          end
        end
        WB: begin
          if (beat_ack) begin
            if (beat == LAST_BEAT) begin
              state    <= FILL;
              beat     <= '0;
              mem_we   <= 1'b0;
              mem_addr <= {cpu_tag, cpu_idx, BEAT_ZERO};
            end else begin
              beat     <= next_beat;
              mem_addr <= {tag_q[cpu_idx], cpu_idx, next_beat};
            end
          end
        end
        FILL: begin
          if (fill_snooped) fill_killed <= 1'b1;
          if (beat_ack) begin
            if (beat == LAST_BEAT) begin
              state   <= DONE;
              beat    <= '0;
              mem_req <= 1'b0;
            end else begin
              beat     <= next_beat;
              mem_addr <= {cpu_tag, cpu_idx, next_beat};
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          fill_killed <= 1'b0;
          read_miss   <= 1'b0;
          write_miss  <= 1'b0;
        end
      endcase
    end
  end

  // The CPU must hold its request for the whole miss.
  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
                               (state != IDLE) |-> cpu_req);

endmodule
